// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key-expansion engine.
//   key_len_t : key length code as sampled on start
//   state_t   : expansion FSM states
//   xtime     : GF(2^8) multiply by x (used to advance rcon)
//   rot_word  : cyclic left byte rotation of a schedule word
//   nk_of     : key length in words (0 for an illegal code)
//   nr_of     : number of rounds (0 for an illegal code)
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2
  } key_len_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
//   in_byte  : input byte
//   out_byte : S(in_byte)
// Computed as the GF(2^8) inverse (x^254, so 0 maps to 0) followed by the
// AES affine transform, instead of a 256-entry table.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, in_byte);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, in_byte);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, in_byte);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, in_byte);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, in_byte);
    inv  = gf_mul(x127, x127);
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key-expansion engine.
//   clk, reset          : clock, asynchronous active-high reset
//   start, key_len      : begin a key load; key_len 0/1/2 = AES-128/192/256
//   key_word, key_valid : cipher key stream, w[0] first
//   key_ready           : high while loading key words
//   rd_en, rd_round,
//   rd_word             : read request for w[4*rd_round + rd_word]
//   rd_data, rd_valid,
//   rd_err              : registered read response (rd_err: round > Nr)
//   busy, done, cfg_err : status; cfg_err pulses on a rejected start
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  key_len,
  input  logic [31:0] key_word,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        rd_en,
  input  logic [3:0]  rd_round,
  input  logic [1:0]  rd_word,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  localparam int NW = 4 * (MAX_NK + 7);

  state_t      state;
  logic [3:0]  nk;
  logic [3:0]  nr;
  logic [5:0]  idx;
  logic [2:0]  kmod;      // idx mod Nk, kept as a wrapping counter
  logic [7:0]  rcon;
  logic [31:0] win [8];   // win[0] = w[i-1] ... win[Nk-1] = w[i-Nk]
  logic [31:0] mem [NW];

  logic [31:0] w_prev, w_back, sub_in, sub_out, t, wdata;
  logic        we;
  logic [3:0]  nk_req;
  logic        start_ok;
  logic [5:0]  rd_addr;

  assign nk_req   = nk_of(key_len);
  assign start_ok = (nk_req != 4'd0) && (int'(nk_req) <= MAX_NK);
  assign w_prev   = win[0];
  assign w_back   = win[3'(nk - 4'd1)];

  assign key_ready = (state == LOAD);
  assign busy      = (state == LOAD) || (state == EXPAND);

  // One SubWord shared by the rcon step and the AES-256 mid-key step.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    sub_in = (kmod == 3'd0) ? rot_word(w_prev) : w_prev;
    if (kmod == 3'd0)
      t = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && kmod == 3'd4)
      t = sub_out;
    else
      t = w_prev;
    we    = 1'b0;
    wdata = w_back ^ t;
    case (state)
      LOAD: begin
        we    = key_valid;
        wdata = key_word;
      end
      EXPAND:  we = 1'b1;
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      nk      <= '0;
      nr      <= '0;
      idx     <= '0;
      kmod    <= '0;
      rcon    <= 8'h01;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      for (int unsigned k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (we) begin
        win[0] <= wdata;
        for (int unsigned k = 1; k < 8; k++) win[k] <= win[k-1];
        idx  <= idx + 6'd1;
        kmod <= (kmod == 3'(nk - 4'd1)) ? '0 : kmod + 3'd1;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (start_ok) begin
              nk    <= nk_req;
              nr    <= nr_of(key_len);
              done  <= 1'b0;
              idx   <= '0;
              kmod  <= '0;
              rcon  <= 8'h01;
              state <= LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (we && idx == 6'(nk - 4'd1)) state <= EXPAND;
        end
        EXPAND: begin
          if (kmod == 3'd0) rcon <= xtime(rcon);
          // Last word index is 4*(Nr+1)-1 = 4*Nr+3.
          if (idx == {nr, 2'b11}) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_addr = {rd_round, rd_word};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && (rd_round > nr);
      if (rd_en) rd_data <= (int'(rd_addr) < NW) ? mem[rd_addr] : '0;
    end
  end

endmodule
